uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial receiver that consumes the line driven by our uart_tx stage. It recovers NUM_WORDS words per transfer, assembles them into one W_OUT-bit beat, and presents the beat on a valid/ready master interface to the downstream datapath. Line format matches uart_tx exactly:
- Per word: start bit 0, then data bits LSB first and inverted on the line, then one or more stop bits of 1.
- Words travel in index order, word 0 first.

Parameters:
CLOCKS_PER_PULSE, 4, clocks per bit period (integer >= 2; 200_000_000/9600 in system).
BITS_PER_WORD, 8, data bits per word.
W_OUT, 24, total output width; must be a multiple of BITS_PER_WORD.
NUM_WORDS, W_OUT/BITS_PER_WORD, localparam; words per output beat.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
rx  in  1  serial line, asynchronous to clk, idle high.
m_data  out  [NUM_WORDS-1:0][BITS_PER_WORD-1:0]  assembled beat; m_data[0] is the first word received.
m_valid  out  1  beat available.
m_ready  in  1  downstream accepts the beat when m_valid && m_ready.
frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
overrun  out  1  one-cycle pulse when a completed beat is dropped because the output is still held.

Behaviour:
Reset values:
- m_data=0, m_valid=0, frame_err=0, overrun=0.
- state=IDLE; word index, bit and clock counters all 0.
- Synchroniser flops=1.

Input synchronisation:
- rx passes through a 2-flop synchroniser; rx_s is its output.
- All decisions use rx_s, so the line-to-decision latency is 2 cycles.

States: IDLE, START, DATA, STOP.
- IDLE: when rx_s==0, go to START with c_clocks=0.
- START: c_clocks increments each cycle. At c_clocks==(CLOCKS_PER_PULSE-1)/2, sample rx_s.
  - Sample 0: go to DATA, c_clocks=0, c_bits=0.
  - Sample 1: glitch; return to IDLE with no other effect.
- DATA: at c_clocks==CLOCKS_PER_PULSE-1, sample ~rx_s into shift[c_bits] (LSB first, inversion removed), set c_clocks=0, increment c_bits.
  - After BITS_PER_WORD samples, go to STOP.
- STOP: at c_clocks==CLOCKS_PER_PULSE-1, sample rx_s.
  - Sample 1: write the word into assembly register slot c_word and go to IDLE.
    - If c_word < NUM_WORDS-1: increment c_word.
    - If c_word == NUM_WORDS-1: the beat is complete; set c_word=0.
  - Sample 0: pulse frame_err for 1 cycle, discard all partial words (c_word=0), go to IDLE. IDLE waits for rx_s high before arming: a held-low line must not retrigger START.
- Any number of stop bits >= 1 is tolerated. Only the first is checked.

Output register:
- Separate from the assembly register, so reception continues while a beat is held.
- On beat completion with m_valid==0, or with m_valid && m_ready in the same cycle:
  - m_data takes the assembled beat; m_valid=1 on the next edge.
  - Latency: m_valid rises 1 cycle after the final stop-bit sample.
- On beat completion with m_valid && !m_ready:
  - Held m_data is unchanged.
  - The new beat is dropped and overrun pulses for 1 cycle.
- Handshake: m_valid && m_ready with no completion clears m_valid on the next edge.
- m_data is stable while m_valid && !m_ready.

Boundaries and invariants:
- c_word persists across idle gaps. There is no inter-word timeout; only a framing error or reset resynchronises c_word.
- frame_err and overrun are never asserted for more than 1 consecutive cycle each.
- rst asserted mid-frame returns immediately to the reset values. A beat that is partially received or held is lost.
- rx toggling while in rst has no effect.

Counter widths:
- c_clocks: $clog2(CLOCKS_PER_PULSE).
- c_bits: $clog2(BITS_PER_WORD+1).
- c_word: $clog2(NUM_WORDS), minimum 1 bit.

Test Plan:
- Loopback: uart_tx (CLOCKS_PER_PULSE=4) sends s_data={8'hA5,8'h3C,8'hF0}, m_ready=1 -> one m_valid pulse with m_data=={8'hA5,8'h3C,8'hF0}, m_data[0]==8'hF0; frame_err=0, overrun=0.
- Glitch: rx low for 1 clk, then high -> state returns to IDLE, no m_valid, no frame_err; a following valid transfer of {8'h01,8'h80,8'hFF} is received intact.
- Framing error: drive a hand-built frame where the word 1 stop bit is 0 -> frame_err pulses exactly once, no m_valid; the next clean transfer {8'h11,8'h22,8'h33} is received correctly with word alignment restored.
- Backpressure: m_ready=0, send beats B1={8'h12,8'h34,8'h56} then B2={8'h9A,8'hBC,8'hDE} -> m_valid=1 holding B1, overrun pulses once at B2 completion; raise m_ready -> B1 accepted, m_valid=0.
- Reset mid-operation: assert rst during DATA of word 1 -> all outputs 0 asynchronously; after release, a full transfer {8'hC3,8'h5A,8'h0F} is received with m_data[0]==8'h0F.
- Back-to-back: 4 consecutive uart_tx transfers with m_ready=1 and random 24-bit data -> 4 m_valid handshakes, data matches in order, no errors.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - serial receiver assembling NUM_WORDS words into one valid/ready beat
`timescale 1ns/1ps
//
// Purpose:
//   Receives words framed as start(0), BITS_PER_WORD inverted data bits LSB
//   first, then one or more stop bits (1). NUM_WORDS consecutive words are
//   collected in an assembly register and handed to a separate output
//   register, so reception carries on while a finished beat waits for the
//   downstream side.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   rx         serial line, asynchronous to clk, idle high
//   m_data     assembled beat, m_data[0] is the first word received
//   m_valid    beat available
//   m_ready    downstream accepts the beat when m_valid && m_ready
//   frame_err  one-cycle pulse when a stop bit is sampled low
//   overrun    one-cycle pulse when a completed beat is dropped while the
//              output register is still held
module uart_rx #(
   parameter  int CLOCKS_PER_PULSE = 4,
   parameter  int BITS_PER_WORD    = 8,
   parameter  int W_OUT            = 24,
   localparam int NUM_WORDS        = W_OUT / BITS_PER_WORD
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      rx,
   output logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]   m_data,
   output logic                                      m_valid,
   input  logic                                      m_ready,
   output logic                                      frame_err,
   output logic                                      overrun
);

   localparam int CW = $clog2(CLOCKS_PER_PULSE);
   localparam int BW = $clog2(BITS_PER_WORD + 1);
   localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   // Start bit is checked near its middle; data and stop bits are then
   // sampled one full bit period apart, which keeps them mid-bit as well.
   localparam logic [CW-1:0] HALF_CNT  = CW'((CLOCKS_PER_PULSE - 1) / 2);
   localparam logic [CW-1:0] LAST_CNT  = CW'(CLOCKS_PER_PULSE - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(BITS_PER_WORD - 1);
   localparam logic [WW-1:0] LAST_WORD = WW'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                                  state_q;
   state_t                                  state_d;

   logic                                    rx_meta;
   logic                                    rx_s;

   logic [CW-1:0]                           c_clocks;
   logic [BW-1:0]                           c_bits;
   logic [WW-1:0]                           c_word;

   logic [BITS_PER_WORD-1:0]                shift_q;
   logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] asm_q;

   // Cleared by a framing error so that a line stuck low (break) cannot
   // immediately retrigger a start; re-armed once the line is seen high.
   logic                                    line_armed;

   logic                                    start_tick;
   logic                                    bit_tick;
   logic                                    stop_tick;
   logic                                    word_ok;
   logic                                    word_bad;
   logic                                    beat_done;
   logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] beat_assembled;

   // Two-flop synchroniser; resets to the idle line level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (line_armed && !rx_s) begin
               state_d = START;
            end
         end
         START: begin
            // A start bit that is high again at mid-bit was a glitch.
            if (start_tick) begin
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_tick && (c_bits == LAST_BIT)) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (stop_tick) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Decoded strobes driving the datapath.
   always_comb begin
      start_tick = (state_q == START) && (c_clocks == HALF_CNT);
      bit_tick   = (state_q == DATA)  && (c_clocks == LAST_CNT);
      stop_tick  = (state_q == STOP)  && (c_clocks == LAST_CNT);
      word_ok    = stop_tick && rx_s;
      word_bad   = stop_tick && !rx_s;
      beat_done  = word_ok && (c_word == LAST_WORD);
      // Assembly register with the word just finished merged into its slot;
      // on the last word this is the complete beat.
      for (int i = 0; i < NUM_WORDS; i++) begin
         beat_assembled[i] = (WW'(i) == c_word) ? shift_q : asm_q[i];
      end
   end

   // Counters, shift/assembly registers and the output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_clocks   <= '0;
         c_bits     <= '0;
         c_word     <= '0;
         shift_q    <= '0;
         asm_q      <= '0;
         line_armed <= 1'b1;
         m_data     <= '0;
         m_valid    <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= word_bad;
         overrun   <= beat_done && m_valid && !m_ready;

         case (state_q)
            IDLE: begin
               c_clocks <= '0;
               if (rx_s) begin
                  line_armed <= 1'b1;
               end
            end
            START: begin
               if (start_tick) begin
                  c_clocks <= '0;
                  c_bits   <= '0;
               end else begin
                  c_clocks <= c_clocks + CW'(1);
               end
            end
            DATA: begin
               if (bit_tick) begin
                  c_clocks <= '0;
                  c_bits   <= c_bits + BW'(1);
                  // Shift in from the top so the first bit ends up in bit 0;
                  // the line carries inverted data.
                  shift_q  <= {~rx_s, shift_q[BITS_PER_WORD-1:1]};
               end else begin
                  c_clocks <= c_clocks + CW'(1);
               end
            end
            STOP: begin
               if (stop_tick) begin
                  c_clocks <= '0;
                  if (rx_s) begin
                     asm_q  <= beat_assembled;
                     c_word <= beat_done ? '0 : c_word + WW'(1);
                  end else begin
                     // Drop any partial beat so the next transfer starts
                     // word-aligned.
                     c_word     <= '0;
                     line_armed <= 1'b0;
                  end
               end else begin
                  c_clocks <= c_clocks + CW'(1);
               end
            end
            default: begin
               c_clocks <= '0;
            end
         endcase

         // A completed beat is only taken when the output slot is free or is
         // being emptied this cycle; otherwise the held beat wins.
         if (beat_done && (!m_valid || m_ready)) begin
            m_data  <= beat_assembled;
            m_valid <= 1'b1;
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int CPP = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            rx = 1'b1;
   logic            m_ready = 1'b0;
   logic [2:0][7:0] m_data;
   logic            m_valid;
   logic            frame_err;
   logic            overrun;

   uart_rx #(
      .CLOCKS_PER_PULSE(CPP),
      .BITS_PER_WORD(8),
      .W_OUT(24)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .m_data(m_data),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .frame_err(frame_err),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [23:0] exp_q[$];
   int          handshakes = 0;
   int          seen_fe = 0;
   int          seen_ov = 0;
   int          exp_fe = 0;
   int          exp_ov = 0;
   logic        fe_prev = 1'b0;
   logic        ov_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and tracks error pulses.
   always @(negedge clk) begin
      if (rst) begin
         fe_prev = 1'b0;
         ov_prev = 1'b0;
      end else begin
         if (frame_err) begin
            seen_fe++;
            check("frame_err_width", {31'd0, fe_prev}, 32'd0);
         end
         if (overrun) begin
            seen_ov++;
            check("overrun_width", {31'd0, ov_prev}, 32'd0);
         end
         fe_prev = frame_err;
         ov_prev = overrun;
         if (m_valid && m_ready) begin
            handshakes++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got %0h, expected no beat", m_data);
            end else begin
               check("beat_data", {8'd0, m_data}, {8'd0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic v);
      rx = v;
      idle(CPP);
   endtask

   task automatic send_word(input logic [7:0] w, input logic stop_val);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         drive_bit(~w[i]);
      end
      drive_bit(stop_val);
      rx = 1'b1;
   endtask

   // Word 0 is the low byte of d, matching m_data[0].
   task automatic send_beat(input logic [23:0] d, input logic expect_beat);
      if (expect_beat) begin
         exp_q.push_back(d);
      end
      send_word(d[7:0], 1'b1);
      send_word(d[15:8], 1'b1);
      send_word(d[23:16], 1'b1);
   endtask

   task automatic check_events(input string phase);
      check({phase, "_frame_err_count"}, seen_fe, exp_fe);
      check({phase, "_overrun_count"}, seen_ov, exp_ov);
   endtask

   logic [23:0] b2b [4] = '{24'h13579B, 24'hFFFFFF, 24'h000000, 24'h6D2E81};

   initial begin
      rst = 1'b1;
      rx = 1'b1;
      m_ready = 1'b0;
      idle(3);
      check("reset_m_valid", {31'd0, m_valid}, 32'd0);
      check("reset_m_data", {8'd0, m_data}, 32'd0);
      check("reset_frame_err", {31'd0, frame_err}, 32'd0);
      check("reset_overrun", {31'd0, overrun}, 32'd0);
      rst = 1'b0;
      idle(5);

      // Loopback beat.
      m_ready = 1'b1;
      send_beat(24'hA53CF0, 1'b1);
      idle(10);
      check("loopback_handshakes", handshakes, 1);
      check_events("loopback");

      // One-clock glitch must not start a frame.
      rx = 1'b0;
      idle(1);
      rx = 1'b1;
      idle(12);
      check("glitch_no_beat", handshakes, 1);
      check("glitch_m_valid", {31'd0, m_valid}, 32'd0);
      check_events("glitch");
      send_beat(24'h0180FF, 1'b1);
      idle(10);
      check("post_glitch_handshakes", handshakes, 2);

      // Framing error on the stop bit of word 1.
      send_word(8'h55, 1'b1);
      send_word(8'hAA, 1'b0);
      exp_fe++;
      idle(12);
      check("frame_no_beat", handshakes, 2);
      check_events("frame");
      send_beat(24'h112233, 1'b1);
      idle(10);
      check("post_frame_handshakes", handshakes, 3);
      check_events("post_frame");

      // Backpressure: B1 held, B2 dropped with overrun.
      m_ready = 1'b0;
      send_beat(24'h123456, 1'b1);
      send_beat(24'h9ABCDE, 1'b0);
      exp_ov++;
      idle(6);
      check_events("backpressure");
      check("held_m_valid", {31'd0, m_valid}, 32'd1);
      check("held_m_data", {8'd0, m_data}, 32'h00123456);
      m_ready = 1'b1;
      idle(3);
      check("released_m_valid", {31'd0, m_valid}, 32'd0);
      check("released_handshakes", handshakes, 4);

      // Reset while a beat is held and word 1 of the next is in DATA.
      m_ready = 1'b0;
      send_beat(24'h777777, 1'b0);
      idle(4);
      send_word(8'h3C, 1'b1);
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
      check("midrst_m_data", {8'd0, m_data}, 32'd0);
      check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
      check("midrst_overrun", {31'd0, overrun}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         rx = ~rx;
         @(posedge clk);
      end
      #1;
      rx = 1'b1;
      check("inrst_m_valid", {31'd0, m_valid}, 32'd0);
      idle(3);
      rst = 1'b0;
      idle(5);
      m_ready = 1'b1;
      send_beat(24'hC35A0F, 1'b1);
      idle(10);
      check("post_reset_handshakes", handshakes, 5);
      check_events("post_reset");

      // Back-to-back transfers.
      for (int i = 0; i < 4; i++) begin
         send_beat(b2b[i], 1'b1);
      end

      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
         @(posedge clk);
      end
      idle(5);
      check("queue_drained", exp_q.size(), 0);
      check("final_handshakes", handshakes, 9);
      check("final_m_valid", {31'd0, m_valid}, 32'd0);
      check_events("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
